// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_pkg
//  Brief    : Shared types and default sizing for the register-file dumper.
//             The CSUM state only exists when REG_DUMP_CSUM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

  localparam int DEFAULT_DW   = 32;
  localparam int DEFAULT_NREG = 32;
  localparam int IDX_W        = 5;

`ifdef REG_DUMP_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_CSUM  = 3'd3,
    S_FIN   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_FIN   = 3'd4
  } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump
//  Brief    : Walks register indices 0..NREG-1 through a combinational read
//             port and streams each value out on a valid/ready interface,
//             followed by a done pulse. With REG_DUMP_CSUM_EN defined, an
//             extra XOR checksum word is appended as the final word.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int DW   = DEFAULT_DW,
  parameter int NREG = DEFAULT_NREG
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  output logic [IDX_W-1:0] rn,
  input  logic [DW-1:0]    q,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_csum,
  output logic             done
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NREG - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
`ifdef REG_DUMP_CSUM_EN
  logic [DW-1:0]    acc_q, acc_d;
  logic             out_csum_q, out_csum_d;
`endif

  // State, index, accumulator and output-word registers.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
      acc_q       <= '0;
      out_csum_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
`ifdef REG_DUMP_CSUM_EN
      acc_q       <= acc_d;
      out_csum_q  <= out_csum_d;
`endif
    end
  end

  // Next-state logic; the output word is only reloaded in FETCH/CSUM so it
  // stays frozen while the consumer stalls.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
`ifdef REG_DUMP_CSUM_EN
    acc_d       = acc_q;
    out_csum_d  = out_csum_q;
`endif
    rn   = '0;
    busy = (state_q != S_IDLE);
    done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
`ifdef REG_DUMP_CSUM_EN
          acc_d   = '0;
`endif
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        rn          = idx_q;
        out_data_d  = q;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CSUM_EN
        // The checksum word is the final one, so data words never carry last.
        out_last_d  = 1'b0;
        out_csum_d  = 1'b0;
        acc_d       = acc_q ^ q;
`else
        out_last_d  = (idx_q == c_last_idx);
`endif
        state_d     = S_SEND;
      end

      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q < c_last_idx) begin
            idx_d   = idx_q + 5'd1;
            state_d = S_FETCH;
          end else begin
`ifdef REG_DUMP_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_FIN;
`endif
          end
        end
      end

`ifdef REG_DUMP_CSUM_EN
      S_CSUM: begin
        // First cycle loads the checksum word; it then waits for acceptance.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_idx_d   = '0;
          out_last_d  = 1'b1;
          out_csum_d  = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_csum_d  = 1'b0;
          state_d     = S_FIN;
        end
      end
`endif

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
`ifdef REG_DUMP_CSUM_EN
  assign out_csum  = out_csum_q;
`else
  assign out_csum  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump
//  Brief    : Self-checking bench for reg_dump. A transaction-level model
//             (expected word number, active flag, pending done) is compared
//             against the DUT on every falling edge. Honours REG_DUMP_CSUM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump;
  import reg_dump_pkg::*;

  localparam int DW   = 32;
  localparam int NREG = 32;
`ifdef REG_DUMP_CSUM_EN
  localparam int LASTK    = NREG;      // word number of the final (checksum) word
  localparam int DONE_LAT = 67;
`else
  localparam int LASTK    = NREG - 1;
  localparam int DONE_LAT = 65;
`endif

  logic          clk = 1'b0;
  logic          clrn, start, out_ready;
  logic          busy, out_valid, out_last, out_csum, done;
  logic [4:0]    rn, out_idx;
  logic [DW-1:0] q, out_data;
  logic [DW-1:0] regs [NREG];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Register file read port is purely combinational.
  assign q = regs[rn];

  reg_dump #(.DW(DW), .NREG(NREG)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .start     (start),
    .rn        (rn),
    .q         (q),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_csum  (out_csum),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] xor_all();
    logic [DW-1:0] x;
    x = '0;
    for (int i = 0; i < NREG; i++) x ^= regs[i];
    return x;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  bit            mon_en     = 1'b0;
  bit            m_active   = 1'b0;
  bit            m_done     = 1'b0;
  bit            first_pend = 1'b0;
  int            m_k        = 0;
  int            cyc_n      = 0;
  int            m_start    = 0;
  int            first_lat  = -1;
  int            done_lat   = -1;
  int            hs_cnt     = 0;
  int            done_cnt   = 0;
  logic [DW-1:0] cap [NREG];

  always @(negedge clk) begin
    if (mon_en) begin
      cyc_n++;
      check("busy", 64'(busy), 64'(m_active));
      check("done", 64'(done), 64'(m_done));
      if (!busy) check("rn_idle", 64'(rn), 64'd0);
      if (done) begin
        done_cnt++;
        done_lat = cyc_n - m_start;
      end
      if (out_valid) begin
        if (!m_active || m_k > LASTK) begin
          n_cmp++;
          n_fail++;
          $display("FAIL valid_unexpected: actual out_valid=1 required 0 (t=%0t)", $time);
        end else if (m_k < NREG) begin
          check("word_data", 64'(out_data), 64'(regs[m_k]));
          check("word_idx",  64'(out_idx),  64'(m_k));
          check("word_last", 64'(out_last), 64'((LASTK == NREG - 1) && (m_k == NREG - 1)));
          check("word_csum", 64'(out_csum), 64'd0);
        end else begin
          check("csum_data", 64'(out_data), 64'(xor_all()));
          check("csum_idx",  64'(out_idx),  64'd0);
          check("csum_last", 64'(out_last), 64'd1);
          check("csum_flag", 64'(out_csum), 64'd1);
        end
        if (first_pend) begin
          first_lat  = cyc_n - m_start;
          first_pend = 1'b0;
        end
      end
      // advance the model across the coming rising edge
      if (clrn) begin
        m_active   = 1'b0;
        m_done     = 1'b0;
        m_k        = 0;
        first_pend = 1'b0;
      end else if (m_done) begin
        m_done   = 1'b0;
        m_active = 1'b0;
      end else if (m_active && out_valid && out_ready) begin
        if (m_k < NREG) cap[m_k] = out_data;
        hs_cnt++;
        if (m_k == LASTK) m_done = 1'b1;
        m_k++;
      end else if (!m_active && start) begin
        m_active   = 1'b1;
        m_k        = 0;
        hs_cnt     = 0;
        m_start    = cyc_n;
        first_pend = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One dump; optional backpressure, start-while-busy, live write and
  // mid-dump reset triggers (negative index disables a trigger).
  task automatic do_dump(input bit rnd, input int bp_idx, input int again_idx,
                         input int live_idx, input int rst_idx, output bit got_done);
    int cyc;
    int hold;
    cyc      = 0;
    hold     = 0;
    got_done = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!got_done && cyc < 2000) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (rnd) begin
          out_ready = ($urandom_range(0, 1) == 1);
          start     = ($urandom_range(0, 7) == 0);
        end else begin
          start = 1'b0;
        end
        if (bp_idx >= 0 && hold == 0 && busy && rn == 5'(bp_idx)) begin
          out_ready = 1'b0;
          hold      = 6;
        end else if (hold > 1) begin
          check("bp_valid", 64'(out_valid), 64'd1);
          check("bp_idx",   64'(out_idx),   64'(bp_idx));
          check("bp_data",  64'(out_data),  64'(regs[bp_idx]));
          hold--;
        end else if (hold == 1) begin
          out_ready = 1'b1;
          hold      = 0;
        end
        if (again_idx >= 0 && busy && rn == 5'(again_idx)) start = 1'b1;
        if (live_idx >= 5 && busy && rn == 5'(live_idx - 5)) regs[live_idx] = 32'hDEADBEEF;
        if (rst_idx >= 0 && out_valid && !out_csum && out_idx == 5'(rst_idx)) begin
          clrn = 1'b1;
          @(posedge clk); #1;
          check("rst_valid", 64'(out_valid), 64'd0);
          check("rst_busy",  64'(busy),      64'd0);
          check("rst_done",  64'(done),      64'd0);
          check("rst_data",  64'(out_data),  64'd0);
          clrn      = 1'b0;
          start     = 1'b0;
          out_ready = 1'b1;
          @(negedge clk); #1;
          return;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!got_done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL dump_timeout: actual no done after %0d cycles, required done", cyc);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    bit ok;
    int d0;
    clrn      = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NREG; i++) regs[i] = 32'(i) * 32'h11111111;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data",  64'(out_data),  64'd0);
    check("reset_idx",   64'(out_idx),   64'd0);
    check("reset_last",  64'(out_last),  64'd0);
    check("reset_csum",  64'(out_csum),  64'd0);
    check("reset_done",  64'(done),      64'd0);
    check("reset_busy",  64'(busy),      64'd0);
    check("reset_rn",    64'(rn),        64'd0);
    clrn   = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // basic dump with ready held high
    do_dump(1'b0, -1, -1, -1, -1, ok);
    check("t1_done",      64'(ok),        64'd1);
    check("t1_first_lat", 64'(first_lat), 64'd2);
    check("t1_done_lat",  64'(done_lat),  64'(DONE_LAT));
    check("t1_words",     64'(hs_cnt),    64'(LASTK + 1));
    check("t1_word0",     64'(cap[0]),    64'h0);
    check("t1_word5",     64'(cap[5]),    64'h55555555);
    check("t1_word31",    64'(cap[31]),   64'h1111110F);
    idle(3);

    // backpressure on index 3
    do_dump(1'b0, 3, -1, -1, -1, ok);
    check("t2_done",  64'(ok),     64'd1);
    check("t2_words", 64'(hs_cnt), 64'(LASTK + 1));
    idle(3);

    // start pulses while busy are ignored
    d0 = done_cnt;
    do_dump(1'b0, -1, 10, -1, -1, ok);
    idle(80);
    check("t4_done",     64'(ok),            64'd1);
    check("t4_one_done", 64'(done_cnt - d0), 64'd1);
    check("t4_words",    64'(hs_cnt),        64'(LASTK + 1));

    // reset in the middle of a dump, then a fresh dump
    d0 = done_cnt;
    do_dump(1'b0, -1, -1, -1, 7, ok);
    idle(5);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    do_dump(1'b0, -1, -1, -1, -1, ok);
    check("t5_redump",  64'(ok),     64'd1);
    check("t5_words",   64'(hs_cnt), 64'(LASTK + 1));
    check("t5_word0",   64'(cap[0]), 64'h0);
    idle(3);

    // live write to index 20 ahead of its fetch
    do_dump(1'b0, -1, -1, 20, -1, ok);
    check("t6_done",   64'(ok),      64'd1);
    check("t6_word20", 64'(cap[20]), 64'hDEADBEEF);
    idle(3);

    // random contents, random backpressure, random stray starts
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NREG; i++) regs[i] = $urandom;
      do_dump(1'b1, -1, -1, -1, -1, ok);
      check("rnd_done",  64'(ok),     64'd1);
      check("rnd_words", 64'(hs_cnt), 64'(LASTK + 1));
      idle(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter DW, default 32, data word width, equal to the register file word width.
REQ-002 SHALL have parameter NREG, default 32, number of registers dumped (indices 0..NREG-1).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port clrn  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port rn  output  5  read-port register index driven to the register file.
REQ-007 SHALL have port q  input  DW  combinational read data returned for rn.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port out_valid  output  1  out_data/out_idx/out_last/out_csum valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the current word.
REQ-011 SHALL have port out_data  output  DW  dumped register value or checksum.
REQ-012 SHALL have port out_idx  output  5  register index of out_data.
REQ-013 SHALL have port out_last  output  1  final word of the dump.
REQ-014 SHALL have port out_csum  output  1  out_data is the checksum word.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last handshake.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, SEND, CSUM and FIN.
REQ-017 IDLE: start=1 SHALL set idx=0, clear the checksum accumulator and go to FETCH; start=0 SHALL stay in IDLE.
REQ-018 FETCH: rn SHALL equal idx; on the next edge q SHALL be latched into out_data, idx into out_idx, the accumulator SHALL update to acc^q, out_valid SHALL be set, and the FSM SHALL go to SEND.
REQ-019 SEND: while out_ready=0, all out_* signals SHALL hold stable.
REQ-020 SEND handshake (out_valid&&out_ready): out_valid SHALL clear; if idx<NREG-1, idx SHALL increment and the FSM SHALL go to FETCH; otherwise it SHALL go to CSUM (macro defined) or FIN.
REQ-021 Throughput SHALL be one word per 2 cycles with out_ready held high; out_valid SHALL first rise 2 cycles after start is sampled.
REQ-022 rn SHALL be 0 in IDLE, FIN and CSUM.
REQ-023 FIN: done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-024 start while busy SHALL be ignored and SHALL NOT restart or queue a dump.
REQ-025 Register-file writes during a dump SHALL NOT be blocked; each word SHALL reflect q at its own FETCH cycle.
REQ-026 Index 0 SHALL be dumped like any other index; its value is whatever q returns.
REQ-027 out_last SHALL be 1 only on the final word of the dump.

Reset
REQ-028 clrn=1 at a clock edge SHALL force IDLE, idx=0, accumulator=0, out_valid=0, out_data=0, out_idx=0, out_last=0, out_csum=0, done=0 and rn=0.
REQ-029 Reset mid-dump SHALL abandon the dump with no done pulse and no further words.

Configuration
REQ-030 The macro REG_DUMP_CSUM_EN SHALL control the checksum feature.
REQ-031 With REG_DUMP_CSUM_EN defined: after the word at index NREG-1 is accepted, CSUM SHALL present out_data=XOR of all dumped words, out_idx=0, out_csum=1 and out_last=1; SHALL hold it until the handshake; and SHALL then go to FIN.
REQ-032 With REG_DUMP_CSUM_EN undefined: the accumulator and CSUM state SHALL be absent, out_csum SHALL be tied to 0, and out_last SHALL accompany index NREG-1.

Structure
REQ-033 Package reg_dump_pkg SHALL hold the state enum type and the default NREG and DW constants.
REQ-034 There SHALL be no sub-module; the FSM, the index counter and the accumulator SHALL be in reg_dump.

Verification
REQ-035 SHALL cover a basic dump: model regfile r[i]=i*0x11111111 (r[0]=0), out_ready=1, pulse start -> 32 words, out_idx 0..31, data matches, first out_valid 2 cycles after start, out_last on idx 31, done 1 cycle later.
REQ-036 SHALL cover backpressure: out_ready low for 5 cycles while the word at idx 3 is presented -> out_data/out_idx stable throughout, no word skipped or duplicated.
REQ-037 SHALL cover the checksum (macro on): same regfile contents -> 33rd word has out_csum=1, out_last=1, out_data=XOR of all r[i].
REQ-038 SHALL cover start while busy: start pulses at idx 10 -> ignored, single dump of 32 words, exactly one done.
REQ-039 SHALL cover reset mid-dump: clrn=1 at idx 7 during SEND -> next cycle out_valid=0, busy=0, no done; a new start then dumps from idx 0.
REQ-040 SHALL cover a live write: write r[20]=0xDEADBEEF before the FETCH of idx 20 -> dumped word 20 = 0xDEADBEEF.
